// File: rtl/dso_capture_ctrl_pkg.sv
// dso_cap_pkg: shared state encoding, trigger codes and helpers for the capture sequencer
package dso_cap_pkg;
    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE, HOLD} state_t;
    localparam logic [1:0] TRIG_OFF  = 2'b00;
    localparam logic [1:0] TRIG_NORM = 2'b01;
    localparam logic [1:0] TRIG_AUTO = 2'b10;
    localparam logic [1:0] SRC_CH1   = 2'b00;
    localparam logic [1:0] SRC_CH2   = 2'b01;
    function automatic logic [3:0] clamp_dec(input logic [3:0] d, input logic [3:0] m);
        return d > m ? m : d;
    endfunction
endpackage

// File: rtl/dso_capture_ctrl_trig_edge_det.sv
// trig_edge_det: synchronizes an async comparator pin and flags the selected edge 3 clk later
module trig_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic trig_edge,
    output logic trig_evt
);
    logic [2:0] sy;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sy       <= '0;
            trig_evt <= 1'b0;
        end else begin
            sy       <= {sy[1:0], pin};
            trig_evt <= trig_edge ? (sy[1] & ~sy[2]) : (~sy[1] & sy[2]);
        end
    end
endmodule

// File: rtl/dso_capture_ctrl.sv
// dso_capture_ctrl: pre/post-trigger capture sequencer driving the circular sample RAM
module dso_capture_ctrl
    import dso_cap_pkg::*;
#(
    parameter int ENTRIES = 512,
    parameter int AW      = 9,
    parameter int MAX_DEC = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trig1,
    input  logic          trig2,
    input  logic [1:0]    trig_src,
    input  logic          trig_edge,
    input  logic [1:0]    trig_type,
    input  logic          capture_done,
    input  logic [AW-1:0] trig_pos,
    input  logic [3:0]    decimator,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] trig_addr,
    output logic          set_capture_done,
    output logic          armed
);
    state_t state, state_n;
    logic [AW-1:0] tp_l, pre_need, wcnt, acnt;
    logic [3:0] dec_l;
    logic [9:0] cnt, per_m1;
    logic evt1, evt2, trig_evt, trig_pend;
    logic active, mode_ok, start, tick, fire, abort;
    trig_edge_det u_det1 (.clk(clk), .rst_n(rst_n), .pin(trig1), .trig_edge(trig_edge), .trig_evt(evt1));
    trig_edge_det u_det2 (.clk(clk), .rst_n(rst_n), .pin(trig2), .trig_edge(trig_edge), .trig_evt(evt2));
    assign trig_evt = trig_src == SRC_CH1 ? evt1 : trig_src == SRC_CH2 ? evt2 : 1'b0;
    assign pre_need = AW'(ENTRIES - 1) - tp_l;
    assign per_m1   = (10'd1 << dec_l) - 10'd1;
    assign active   = state == PRE || state == ARMED || state == POST;
    assign mode_ok  = trig_type == TRIG_NORM || trig_type == TRIG_AUTO;
    assign start    = state == IDLE && mode_ok && !capture_done;
    assign tick     = cnt == per_m1;
    assign abort    = active && !mode_ok;
    // auto-roll forces the trigger on the ENTRIES-th armed tick
    assign fire     = state == ARMED && tick &&
                      (trig_pend || (trig_type == TRIG_AUTO && acnt == AW'(ENTRIES - 1)));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            tp_l             <= '0;
            dec_l            <= '0;
            cnt              <= '0;
            wcnt             <= '0;
            acnt             <= '0;
            trig_pend        <= 1'b0;
            waddr            <= '0;
            trig_addr        <= '0;
            set_capture_done <= 1'b0;
        end else begin
            state            <= state_n;
            set_capture_done <= state_n == DONE && state != DONE;
            tp_l             <= start ? trig_pos : tp_l;
            dec_l            <= start ? clamp_dec(decimator, 4'(MAX_DEC)) : dec_l;
            cnt              <= active ? (tick ? '0 : cnt + 1'b1) : '0;
            wcnt             <= state_n != state ? '0 : (we ? wcnt + 1'b1 : wcnt);
            acnt             <= state == ARMED ? (tick ? acnt + 1'b1 : acnt) : '0;
            trig_pend        <= state == ARMED && !fire && (trig_pend || trig_evt);
            waddr            <= start ? '0 : (we ? waddr + 1'b1 : waddr);
            trig_addr        <= fire && !abort ? waddr : trig_addr;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = trig_pos == AW'(ENTRIES - 1) ? ARMED : PRE;
            PRE:     if (tick && wcnt == pre_need - 1'b1) state_n = ARMED;
            ARMED:   if (fire) state_n = tp_l == '0 ? DONE : POST;
            POST:    if (tick && wcnt == tp_l - 1'b1) state_n = DONE;
            DONE:    if (capture_done) state_n = HOLD;
            HOLD:    if (!capture_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end
    always_comb begin
        we    = tick && active;
        armed = state == ARMED;
    end
endmodule

// File: tb/tb_dso_capture_ctrl.sv
// tb_dso_capture_ctrl: scoreboard bench with an analytic capture-timing reference model
module tb_dso_capture_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, trig1 = 1'b0, trig2 = 1'b0, trig_edge = 1'b1, capture_done = 1'b0;
    logic [1:0] trig_src = 2'b00, trig_type = 2'b00;
    logic [8:0] trig_pos = '0;
    logic [3:0] decimator = '0;
    logic we, set_capture_done, armed;
    logic [8:0] waddr, trig_addr;
    int cyc = 0, n_chk = 0, n_pass = 0, exp_ta = 0, n_ev = 0;
    int wq_c[$], wq_a[$], dq_c[$], dq_ta[$], dq_wa[$];
    int ev_c[4], ev_ch[4], ev_v[4];

    dso_capture_ctrl dut (
        .clk(clk), .rst_n(rst_n), .trig1(trig1), .trig2(trig2), .trig_src(trig_src),
        .trig_edge(trig_edge), .trig_type(trig_type), .capture_done(capture_done),
        .trig_pos(trig_pos), .decimator(decimator), .we(we), .waddr(waddr),
        .trig_addr(trig_addr), .set_capture_done(set_capture_done), .armed(armed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    always @(negedge clk) begin
        if (we) begin
            chk("write_expected", int'(wq_c.size() > 0), 1);
            if (wq_c.size() > 0) begin
                chk("write_cycle", cyc, wq_c.pop_front());
                chk("write_addr", int'(waddr), wq_a.pop_front());
            end
        end
        if (set_capture_done) begin
            chk("done_expected", int'(dq_c.size() > 0), 1);
            if (dq_c.size() > 0) begin
                chk("done_cycle", cyc, dq_c.pop_front());
                chk("done_trig_addr", int'(trig_addr), dq_ta.pop_front());
                chk("done_waddr", int'(waddr), dq_wa.pop_front());
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, int'(we), 0);
        chk({tag, "_waddr"}, int'(waddr), 0);
        chk({tag, "_trig_addr"}, int'(trig_addr), 0);
        chk({tag, "_done"}, int'(set_capture_done), 0);
        chk({tag, "_armed"}, int'(armed), 0);
    endtask

    // Write n lands at relative cycle n*P+P-1 at address n mod 512; the trigger sample is
    // the first armed write strictly after the qualifying event (pin change + 3 clk).
    task automatic run_cap(input int tt, input int tp, input int dec, input int src, input int edg,
                           input int a_in, input bit rst_kind, input bit via_hold, input bit keep);
        int p, pn, armst, eb, t, l, d, wt, lastw, lim, base, endc, p1, p2, pv, a;
        bit ab;
        a = a_in;
        @(negedge clk);
        trig_src = 2'(src); trig_edge = 1'(edg); trig_pos = 9'(tp); decimator = 4'(dec); trig_type = 2'(tt);
        if (via_hold) begin
            capture_done = 1'b0;
            base = cyc + 2;
        end else base = cyc + 1;
        p = 1 << (dec > 9 ? 9 : dec);
        pn = 511 - tp;
        armst = pn * p;
        eb = -1; p1 = 0; p2 = 0;
        for (int i = 0; i < n_ev; i++) begin
            pv = ev_ch[i] != 0 ? p2 : p1;
            if (ev_v[i] != pv && ev_ch[i] == src && ev_v[i] == edg && ev_c[i] + 3 >= armst && eb < 0)
                eb = ev_c[i] + 3;
            if (ev_ch[i] != 0) p2 = ev_v[i]; else p1 = ev_v[i];
        end
        t = eb < 0 ? -1 : (eb + 1) / p;
        if (tt == 2 && (t < 0 || pn + 511 < t)) t = pn + 511;
        if (t < 0 && a < 0) a = armst + 400;
        l = t + tp; d = (l + 1) * p; wt = t * p + p - 1; lastw = l * p + p - 1;
        ab = a >= 0 && (t < 0 || a < d);
        lim = t < 0 ? a : (ab && a < lastw ? a : lastw);
        for (int n = 0; n * p + p - 1 <= lim; n++) begin
            wq_c.push_back(base + n * p + p - 1);
            wq_a.push_back(n % 512);
        end
        if (!ab) begin
            dq_c.push_back(base + d);
            dq_ta.push_back(t % 512);
            dq_wa.push_back((l + 1) % 512);
        end
        if (rst_kind) exp_ta = 0;
        else if (t >= 0 && (!ab || wt < a)) exp_ta = t % 512;
        endc = ab ? a + 2 : d + 2;
        while (cyc - base < endc) begin
            @(negedge clk);
            for (int i = 0; i < n_ev; i++)
                if (ev_c[i] == cyc - base) begin
                    if (ev_ch[i] != 0) trig2 = ev_v[i] != 0; else trig1 = ev_v[i] != 0;
                end
            if (ab && cyc - base == a) begin
                trig_type = 2'b00;
                if (rst_kind) rst_n = 1'b0;
            end
            if (rst_kind && ab && cyc - base == a + 1) begin
                rst_n = 1'b1;
                chk_zero("reset_mid_armed");
            end
        end
        trig1 = 1'b0; trig2 = 1'b0;
        if (!ab) capture_done = 1'b1;
        if (keep) repeat (50) @(negedge clk);
        else begin
            @(negedge clk);
            trig_type = 2'b00; capture_done = 1'b0;
            repeat (8) @(negedge clk);
        end
        chk("left_writes", wq_c.size(), 0);
        chk("left_dones", dq_c.size(), 0);
        chk("trig_addr_after", int'(trig_addr), exp_ta);
        chk("armed_after", int'(armed), 0);
        wq_c.delete(); wq_a.delete(); dq_c.delete(); dq_ta.delete(); dq_wa.delete();
    endtask

    task automatic set_ev(input int i, input int c, input int ch, input int v);
        ev_c[i] = c; ev_ch[i] = ch; ev_v[i] = v;
    endtask

    initial begin
        int tp, dec, src, edg, c1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_ev = 1; set_ev(0, 296, 0, 1);
        run_cap(1, 256, 0, 0, 1, -1, 0, 0, 1);
        chk("normal_trig_addr", int'(trig_addr), 300);
        chk("hold_no_write_waddr", int'(waddr), 45);
        n_ev = 1; set_ev(0, 200, 1, 1);
        run_cap(1, 500, 3, 1, 1, -1, 0, 1, 0);
        n_ev = 0;
        run_cap(1, 300, 15, 0, 1, 3000, 0, 0, 0);
        run_cap(2, 100, 0, 0, 1, -1, 0, 0, 0);
        n_ev = 4; set_ev(0, 50, 0, 1); set_ev(1, 150, 0, 0); set_ev(2, 200, 1, 1); set_ev(3, 300, 0, 1);
        run_cap(1, 400, 0, 0, 1, -1, 0, 0, 0);
        chk("wrong_edge_trig_addr", int'(trig_addr), 304);
        n_ev = 2; set_ev(0, 600, 0, 1); set_ev(1, 700, 1, 1);
        run_cap(1, 200, 0, 2, 1, 5000, 0, 0, 0);
        n_ev = 2; set_ev(0, 1000, 0, 1); set_ev(1, 1100, 0, 0);
        run_cap(1, 0, 1, 0, 0, -1, 0, 0, 0);
        n_ev = 1; set_ev(0, 20, 1, 1);
        run_cap(1, 511, 1, 1, 1, -1, 0, 0, 0);
        n_ev = 1; set_ev(0, 250, 0, 1);
        run_cap(1, 300, 0, 0, 1, 304, 0, 0, 0);
        n_ev = 0;
        run_cap(1, 256, 0, 0, 1, 400, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tp = int'($urandom_range(0, 511));
            dec = int'($urandom_range(0, 2));
            src = int'($urandom_range(0, 1));
            edg = int'($urandom_range(0, 1));
            c1 = (511 - tp) * (1 << dec) + int'($urandom_range(0, 200)) - 100;
            if (c1 < 0) c1 = 0;
            n_ev = 2; set_ev(0, c1, src, 1); set_ev(1, c1 + 5 + int'($urandom_range(0, 300)), src, 0);
            run_cap(int'($urandom_range(1, 2)), tp, dec, src, edg, -1, 0, 0, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dso_capture_ctrl.md
Name: dso_capture_ctrl

Overview:
- Capture sequencer inside DSO_dig, directly downstream of the AFE/A2D model's trig1/trig2 comparator outputs and the ch*_data sample stream.
- Consumes trigger configuration from the command/config registers (TRIG_CFG, trig_pos, decimator).
- Generates sample-RAM write strobes and a circular write address, records the trigger sample address, and pulses set_capture_done when a full buffer with the requested pre/post-trigger split has been captured.

Parameters:
- ENTRIES, 512, sample buffer depth (power of 2).
- AW, 9, address width, log2(ENTRIES).
- MAX_DEC, 9, largest honoured decimator value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- trig1  in  1  AFE comparator 1, asynchronous
- trig2  in  1  AFE comparator 2, asynchronous
- trig_src  in  2  TRIG_CFG cc: 00=trig1, 01=trig2, 1x=none
- trig_edge  in  1  1=rising, 0=falling
- trig_type  in  2  00 off, 01 normal, 10 auto-roll, 11 treated as off
- capture_done  in  1  TRIG_CFG d bit, fed back from the config register
- trig_pos  in  AW  number of post-trigger samples
- decimator  in  4  sample period = 2^decimator clk
- we  out  1  RAM write strobe
- waddr  out  AW  RAM write address
- trig_addr  out  AW  address of the trigger sample
- set_capture_done  out  1  one-cycle pulse
- armed  out  1  high in ARMED

Behaviour:
- Reset (sync, rst_n=0 at posedge): state IDLE; we=0, waddr=0, trig_addr=0, set_capture_done=0, armed=0; sync flops, counters and trig_pend cleared. Reset mid-capture aborts with no done pulse.
- Trigger path:
  - 2-flop synchronizer, then an edge flop; the selected edge asserts trig_evt 3 clk after the pin transitions.
  - trig_src and trig_edge are used live. trig_src=1x never fires.
- Start condition: in IDLE, when trig_type is 01 or 10 and capture_done=0.
  - trig_pos latched to tp_l.
  - min(decimator, MAX_DEC) latched to dec_l.
  - waddr, tick counter and sample counters cleared.
- Decimation:
  - 10-bit counter; smpl_tick when cnt == 2^dec_l-1, then cnt wraps to 0.
  - dec_l=0 gives a tick every cycle, starting on the first cycle after leaving IDLE.
  - we = smpl_tick while in PRE, ARMED or POST. waddr increments mod ENTRIES after each write.
- pre_need = ENTRIES-1-tp_l.
  - PRE: count writes; enter ARMED when the count reaches pre_need.
  - pre_need=0: IDLE goes directly to ARMED.
- ARMED (armed=1):
  - trig_evt sets trig_pend; trig_evt outside ARMED is ignored.
  - On the first smpl_tick with trig_pend=1 (strictly after the trig_evt cycle), that write is the trigger sample: trig_addr<=waddr, trig_pend cleared. Next state is POST, or DONE if tp_l=0.
  - Auto-roll (10): count ticks in ARMED. The ENTRIES-th tick with no pending trigger is forced as the trigger sample.
  - Normal (01): waits indefinitely.
- POST: count writes; after tp_l writes go to DONE.
- DONE:
  - set_capture_done=1 on the entry cycle only.
  - Stay until capture_done=1, then go to HOLD.
- HOLD: no writes; wait for capture_done=0 (host re-arm), then go to IDLE.
- Abort: trig_type becomes 00/11 in PRE, ARMED or POST → IDLE next cycle, no pulse, trig_addr unchanged.
- Buffer content at done: trigger sample followed by tp_l samples, preceded by ENTRIES-1-tp_l samples.

Decomposition:
- Package dso_cap_pkg:
  - state enum {IDLE, PRE, ARMED, POST, DONE, HOLD}.
  - TRIG_OFF=2'b00, TRIG_NORM=2'b01, TRIG_AUTO=2'b10.
  - SRC_CH1=2'b00, SRC_CH2=2'b01.
- Sub-module trig_edge_det: 2-flop synchronizer plus edge flop, selected by trig_edge, producing trig_evt. Instantiated twice, then muxed by trig_src.

Test Plan:
- Normal trigger: trig_type=01, src=00, edge=1, trig_pos=256, dec=0; trig1 rises after armed, with waddr=300 at the trigger tick → trig_addr=300, exactly 256 further writes, single set_capture_done, waddr=45 at done.
- Decimation: dec=3 → we exactly once per 8 clk; dec=15 → period 512 clk (clamped to 9).
- Auto-roll: trig_type=10, trig lines static, trig_pos=100 → forced trigger on the 512th ARMED tick, done after 100 more writes.
- Early/wrong edge: falling edge with edge=1, and rising edge during PRE → no trigger; trig_src=2'b10 with normal mode → no done after 5000 clk.
- Boundaries:
  - trig_pos=0 → DONE right after the trigger write.
  - trig_pos=511 → ARMED on the first cycle and 511 post writes.
- Handshake/abort:
  - After done, capture_done held high → no restart.
  - Dropping capture_done restarts the capture.
  - trig_type→00 mid-POST → IDLE, no pulse.
  - rst_n low for 1 cycle mid-ARMED → all outputs 0.
